// File: rtl/sched_fifo_wr_arb.sv
// sched_fifo_wr_arb: round-robin arbiter that merges NREQ requester beat streams into one
// FIFO write port. A grant lasts up to BURST beats and always ends with one IDLE cycle.
//
// Ports:
//   CLK      - clock, also the FIFO write clock
//   RST      - asynchronous active-high reset
//   REQ      - per-requester valid beat
//   REQ_DATA - per-requester beat data, requester i at [i*DSIZE +: DSIZE]
//   WFULL    - FIFO full; stalls the current grant
//   WDATA    - FIFO write data, always the slice of the granted requester
//   WINC     - FIFO write strobe
//   ACK      - one-hot beat-consumed strobe back to the granted requester
//   GNT_ID   - index of the granted requester
//   BUSY     - high while a grant is active
module sched_fifo_wr_arb #(
    parameter int unsigned DSIZE = 160,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned BURST = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NREQ-1:0]           REQ,
    input  logic [NREQ*DSIZE-1:0]     REQ_DATA,
    input  logic                      WFULL,
    output logic [DSIZE-1:0]          WDATA,
    output logic                      WINC,
    output logic [NREQ-1:0]           ACK,
    output logic [$clog2(NREQ)-1:0]   GNT_ID,
    output logic                      BUSY
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned BW = $clog2(BURST + 1);

    typedef enum logic {StIdle, StXfer} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   gnt_next;
    logic            found;
    logic            req_g;

    // First set REQ bit at or after ptr_q, wrapping past NREQ-1.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IW'((32'(ptr_q) + k) % NREQ);
            if (!found && REQ[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign gnt_next = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
    assign req_g    = REQ[gnt_q];
    assign GNT_ID   = gnt_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        bcnt_d  = bcnt_q;
        WINC    = 1'b0;
        ACK     = '0;
        BUSY    = 1'b0;
        // Data follows the registered grant even when no beat is written.
        WDATA   = REQ_DATA[gnt_q*DSIZE +: DSIZE];
        case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_d   = pick;
                    bcnt_d  = '0;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                BUSY       = 1'b1;
                WINC       = req_g & ~WFULL;
                ACK[gnt_q] = WINC;
                if (!req_g) begin
                    // Requester drop: no beat, release the grant.
                    state_d = StIdle;
                    ptr_d   = gnt_next;
                end else if (WINC) begin
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == BW'(BURST - 1)) begin
                        state_d = StIdle;
                        ptr_d   = gnt_next;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gnt_q   <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            bcnt_q  <= bcnt_d;
        end
    end

endmodule
